// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared between the core and the memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY_IF, BUSY_ME)
//   req_src_t    : which requester owns a bus transaction
//   MEM_READ / MEM_WRITE : polarity of mem_rd_wr (matches core data_rd_wr)
//   word_aligned : true when a byte offset addresses a full 32-bit word
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_ME = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_ME = 1'b1
  } req_src_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter used as the bus transaction watchdog.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
//   clk, reset : clock and synchronous active-high reset
//   load_i     : reload the counter with TIMEOUT-1 (issued on a grant)
//   en_i       : count down while a transaction is outstanding
//   expire_o   : counter has reached zero, i.e. this is the TIMEOUT-th busy cycle
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter between instruction fetch (IF)
// and load/store (ME). One transaction at a time is issued onto the shared bus;
// the arbiter then waits for mem_ready and returns data to the owner.
//   IF side  : if_req/if_addr in; if_gnt, if_valid, if_rdata, if_err out
//   ME side  : me_req/me_we/me_addr/me_wdata in; me_gnt, me_valid, me_rdata, me_err out
//   Bus side : mem_req/mem_addr/mem_wdata/mem_rd_wr out; mem_rdata/mem_ready in
// ME has priority, except that IF is forced after STARVE_MAX consecutive ME
// grants while it waits. Misaligned ME addresses are rejected with me_err.
// Optional feature macro MEM_ARB_TIMEOUT_EN: abort a transaction after TIMEOUT
// busy cycles without mem_ready and report it on if_err/me_err.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [DATA_W-1:0] me_wdata,
  output logic              me_gnt,
  output logic              me_valid,
  output logic [DATA_W-1:0] me_rdata,
  output logic              me_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              if_gnt_q, me_gnt_q, if_valid_q, me_valid_q, me_err_q;
  logic              mem_req_q, mem_rd_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, me_rdata_q;

  logic              busy, me_misaligned, if_forced, do_grant;
  req_src_t          grant_src;

  assign busy          = (state_q != IDLE);
  assign me_misaligned = me_req && !word_aligned(me_addr[1:0]);
  assign if_forced     = if_req && (starve_q == SW'(STARVE_MAX));

  // A misaligned ME request blocks every grant in that cycle, including a
  // forced IF grant; it is answered with me_err only.
  always_comb begin
    do_grant  = 1'b0;
    grant_src = SRC_IF;
    if (!busy && !me_misaligned) begin
      if (me_req && !if_forced) begin
        do_grant  = 1'b1;
        grant_src = SRC_ME;
      end else if (if_req) begin
        do_grant  = 1'b1;
        grant_src = SRC_IF;
      end
    end
  end

  // Counts ME grants that overtook a waiting fetch; any gap in if_req resets it.
  always_comb begin
    starve_d = starve_q;
    if (!if_req) begin
      starve_d = '0;
    end else if (do_grant && (grant_src == SRC_IF)) begin
      starve_d = '0;
    end else if (do_grant && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic timer_expire;
  logic if_err_q;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (do_grant),
    .en_i    (busy),
    .expire_o(timer_expire)
  );

  assign if_err = if_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT;
  assign if_err             = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      me_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      me_valid_q  <= 1'b0;
      me_err_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_wr_q <= MEM_READ;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_err_q    <= 1'b0;
`endif
    end else begin
      if_gnt_q   <= 1'b0;
      me_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      me_valid_q <= 1'b0;
      me_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_err_q   <= 1'b0;
`endif
      starve_q <= starve_d;

      case (state_q)
        IDLE: begin
          if (me_misaligned) begin
            me_err_q <= 1'b1;
          end else if (do_grant) begin
            mem_req_q <= 1'b1;
            if (grant_src == SRC_ME) begin
              state_q     <= BUSY_ME;
              me_gnt_q    <= 1'b1;
              mem_addr_q  <= me_addr;
              mem_wdata_q <= me_wdata;
              mem_rd_wr_q <= me_we ? MEM_WRITE : MEM_READ;
            end else begin
              state_q     <= BUSY_IF;
              if_gnt_q    <= 1'b1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_rd_wr_q <= MEM_READ;
            end
          end
        end

        // mem_ready takes precedence over an expiring watchdog in the same cycle.
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata_q <= mem_rdata;
            if_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timer_expire) begin
            if_err_q  <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
`endif
        end

        BUSY_ME: begin
          if (mem_ready) begin
            if (mem_rd_wr_q == MEM_READ) begin
              me_rdata_q <= mem_rdata;
            end
            me_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timer_expire) begin
            me_err_q  <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
`endif
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign me_gnt    = me_gnt_q;
  assign me_valid  = me_valid_q;
  assign me_rdata  = me_rdata_q;
  assign me_err    = me_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd_wr = mem_rd_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Directed table of single transactions, hand-written multi-cycle sequences
// (priority, starvation, reset mid-transaction, watchdog when
// MEM_ARB_TIMEOUT_EN is defined), then randomized traffic checked against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TB_SMAX    = 4;
  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_valid, if_err;
  logic [31:0] if_rdata;
  logic        me_req = 1'b0;
  logic        me_we = 1'b0;
  logic [31:0] me_addr = '0;
  logic [31:0] me_wdata = '0;
  logic        me_gnt, me_valid, me_err;
  logic [31:0] me_rdata;
  logic        mem_req, mem_rd_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(TB_SMAX),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .me_req   (me_req),
    .me_we    (me_we),
    .me_addr  (me_addr),
    .me_wdata (me_wdata),
    .me_gnt   (me_gnt),
    .me_valid (me_valid),
    .me_rdata (me_rdata),
    .me_err   (me_err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd_wr(mem_rd_wr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed-mode memory: answers lat busy cycles after mem_req rises (0 = never).
  int          lat = 0;
  int          busy_cnt = 0;
  logic [31:0] mem_word = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      busy_cnt++;
      mem_ready = (lat != 0) && (busy_cnt == lat);
    end else begin
      busy_cnt  = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_word;
  endtask

  typedef struct {
    bit          is_me;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          lat;
    bit          exp_err;
    bit          exp_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit got;
    lat      = v.lat;
    mem_word = v.word;
    if (v.is_me) begin
      me_req = 1'b1; me_we = v.we; me_addr = v.addr; me_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    tick();
    if (v.exp_err) begin
      chk($sformatf("vec%0d_me_err", idx), 32'(me_err), 32'd1);
      chk($sformatf("vec%0d_no_gnt", idx), 32'({if_gnt, me_gnt}), 32'd0);
      chk($sformatf("vec%0d_no_memreq", idx), 32'(mem_req), 32'd0);
      me_req = 1'b0;
      tick();
      chk($sformatf("vec%0d_err_single", idx), 32'(me_err), 32'd0);
      chk($sformatf("vec%0d_no_memreq2", idx), 32'(mem_req), 32'd0);
      return;
    end
    chk($sformatf("vec%0d_gnt", idx), 32'({if_gnt, me_gnt}), v.is_me ? 32'd1 : 32'd2);
    chk($sformatf("vec%0d_memreq", idx), 32'(mem_req), 32'd1);
    chk($sformatf("vec%0d_addr", idx), mem_addr, v.addr);
    chk($sformatf("vec%0d_rd_wr", idx), 32'(mem_rd_wr), 32'(v.exp_rd));
    if (v.is_me && v.we) chk($sformatf("vec%0d_wdata", idx), mem_wdata, v.wdata);
    if_req = 1'b0;
    me_req = 1'b0;
    n   = 1;
    got = 1'b0;
    while (n < 30 && !got) begin
      tick();
      n++;
      got = v.is_me ? me_valid : if_valid;
    end
    chk($sformatf("vec%0d_valid_cycle", idx), 32'(n), 32'(v.lat + 1));
    chk($sformatf("vec%0d_rdata", idx), v.is_me ? me_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("vec%0d_memreq_done", idx), 32'(mem_req), 32'd0);
    tick();
  endtask

  // Random-mode snapshots and reference model state.
  logic        s_if, s_me, s_we, s_rdy;
  logic [31:0] s_ifa, s_mea, s_wd, s_rd;
  bit          m_busy, m_src_me, m_rd;
  logic [31:0] m_addr, m_wd, m_if_data, m_me_data;
  int          m_cycles, m_starve;
  bit          if_pend, me_pend, me_w_v;
  logic [31:0] if_a, me_a, me_d_v;
  bit          ex_ifg, ex_meg, ex_ifv, ex_mev, ex_ife, ex_mee, g_if, g_me;

  initial begin
    vec_t v;
    int   exp_seq[6];
    int   ng, hi, errs, vals;

    vecs[0] = '{1'b0, 1'b0, 32'h8002_0000, 32'h0,         32'h1234_5678, 2, 1'b0, 1'b1, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b0, 32'h8012_0004, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h8012_0000, 32'hDEAD_BEEF, 32'h1111_1111, 1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h8012_0002, 32'h0,         32'h0,         1, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h8012_0001, 32'h5555_5555, 32'h0,         1, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1, 1'b0, 1'b1, 32'hFFFF_FFFF};

    // Reset state
    tick();
    tick();
    chk("reset_flags", 32'({if_gnt, if_valid, if_err, me_gnt, me_valid, me_err, mem_req, mem_rd_wr}), 32'h01);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_me_rdata", me_rdata, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous requests: ME store first, IF the cycle after me_valid.
    lat = 1; mem_word = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h8002_0004;
    me_req = 1'b1; me_we = 1'b1; me_addr = 32'h8012_0000; me_wdata = 32'hDEAD_BEEF;
    tick();
    chk("sim_gnt", 32'({if_gnt, me_gnt}), 32'd1);
    chk("sim_me_rd_wr", 32'(mem_rd_wr), 32'd0);
    chk("sim_me_addr", mem_addr, 32'h8012_0000);
    chk("sim_me_wdata", mem_wdata, 32'hDEAD_BEEF);
    me_req = 1'b0;
    tick();
    chk("sim_me_valid", 32'({me_valid, if_gnt}), 32'd2);
    tick();
    chk("sim_if_gnt", 32'(if_gnt), 32'd1);
    chk("sim_if_addr", mem_addr, 32'h8002_0004);
    chk("sim_if_rd_wr", 32'(mem_rd_wr), 32'd1);
    if_req = 1'b0;
    tick();
    chk("sim_if_valid", 32'(if_valid), 32'd1);
    chk("sim_if_rdata", if_rdata, 32'h0BAD_F00D);
    tick();

    // Starvation: ME held with IF waiting -> 4 ME grants, IF, then ME again.
    exp_seq = '{1, 1, 1, 1, 0, 1};
    lat = 1; mem_word = 32'h0;
    if_req = 1'b1; if_addr = 32'h8002_0010;
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h8012_0008;
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick();
      if (if_gnt || me_gnt) begin
        chk($sformatf("starve_grant%0d", ng), 32'({if_gnt, me_gnt}), exp_seq[ng] != 0 ? 32'd1 : 32'd2);
        if (if_gnt) if_req = 1'b0;
        ng++;
      end
    end
    chk("starve_grant_count", 32'(ng), 32'd6);
    me_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // Reset during BUSY_ME abandons the transaction.
    lat = 0;
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h8012_0010;
    tick();
    chk("rst_me_gnt", 32'(me_gnt), 32'd1);
    me_req = 1'b0;
    tick();
    tick();
    chk("rst_busy_memreq", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_flags", 32'({mem_req, mem_rd_wr, me_valid, me_err, if_valid, if_err}), 32'h10);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_me_rdata", me_rdata, 32'h0);
    reset = 1'b0;
    v = '{1'b0, 1'b0, 32'h8002_0020, 32'h0, 32'h600D_CAFE, 2, 1'b0, 1'b1, 32'h600D_CAFE};
    run_vec(v, 10);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: 8 busy cycles without mem_ready -> one if_err, no if_valid.
    lat = 0;
    if_req = 1'b1; if_addr = 32'h8002_0030;
    tick();
    chk("to_if_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    hi = 1; errs = 0; vals = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_req) hi++;
      errs += int'(if_err);
      vals += int'(if_valid);
    end
    chk("to_busy_cycles", 32'(hi), 32'd8);
    chk("to_if_err_count", 32'(errs), 32'd1);
    chk("to_no_valid", 32'(vals), 32'd0);
    // mem_ready on the expiry cycle completes normally.
    v = '{1'b0, 1'b0, 32'h8002_0040, 32'h0, 32'h7777_0001, 8, 1'b0, 1'b1, 32'h7777_0001};
    run_vec(v, 11);
`endif

    // Randomized traffic against the reference model.
    reset = 1'b1; if_req = 1'b0; me_req = 1'b0; lat = 0;
    tick();
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    m_busy = 0; m_src_me = 0; m_rd = 1; m_addr = '0; m_wd = '0;
    m_if_data = '0; m_me_data = '0; m_cycles = 0; m_starve = 0;
    if_pend = 0; me_pend = 0; me_w_v = 0; if_a = '0; me_a = '0; me_d_v = '0;
    for (int it = 0; it < 3000; it++) begin
      s_if = if_req; s_ifa = if_addr; s_me = me_req; s_mea = me_addr;
      s_we = me_we; s_wd = me_wdata; s_rdy = mem_ready; s_rd = mem_rdata;
      @(posedge clk);
      #1;
      ex_ifg = 0; ex_meg = 0; ex_ifv = 0; ex_mev = 0; ex_ife = 0; ex_mee = 0;
      g_if = 0; g_me = 0;
      if (m_busy) begin
        if (s_rdy) begin
          if (m_src_me) begin
            ex_mev = 1;
            if (m_rd) m_me_data = s_rd;
          end else begin
            ex_ifv = 1;
            m_if_data = s_rd;
          end
          m_busy = 0;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          if (m_cycles == TB_TIMEOUT) begin
            if (m_src_me) ex_mee = 1; else ex_ife = 1;
            m_busy = 0;
          end else begin
            m_cycles++;
          end
`else
          m_cycles++;
`endif
        end
      end else if (s_me && s_mea[1:0] != 2'b00) begin
        ex_mee = 1;
      end else if (s_me && !(s_if && m_starve >= TB_SMAX)) begin
        g_me = 1;
      end else if (s_if) begin
        g_if = 1;
      end
      if (g_me) begin
        ex_meg = 1; m_busy = 1; m_src_me = 1; m_addr = s_mea; m_rd = !s_we; m_wd = s_wd; m_cycles = 1;
      end
      if (g_if) begin
        ex_ifg = 1; m_busy = 1; m_src_me = 0; m_addr = s_ifa; m_rd = 1; m_cycles = 1;
      end
      if (!s_if || g_if) m_starve = 0;
      else if (g_me && m_starve < TB_SMAX) m_starve++;

      chk($sformatf("rnd%0d_pulses", it), 32'({if_gnt, me_gnt, if_valid, me_valid, if_err, me_err}),
          32'({ex_ifg, ex_meg, ex_ifv, ex_mev, ex_ife, ex_mee}));
      chk($sformatf("rnd%0d_memreq", it), 32'(mem_req), 32'(m_busy));
      chk($sformatf("rnd%0d_if_rdata", it), if_rdata, m_if_data);
      chk($sformatf("rnd%0d_me_rdata", it), me_rdata, m_me_data);
      if (m_busy) begin
        chk($sformatf("rnd%0d_addr", it), mem_addr, m_addr);
        chk($sformatf("rnd%0d_rd_wr", it), 32'(mem_rd_wr), 32'(m_rd));
        if (!m_rd) chk($sformatf("rnd%0d_wdata", it), mem_wdata, m_wd);
      end

      if (ex_ifg) if_pend = 0;
      if (ex_meg || ex_mee) me_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!me_pend && $urandom_range(0, 2) == 0) begin
        me_pend = 1;
        me_a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) me_a[1:0] = 2'($urandom_range(1, 3));
        me_w_v = $urandom_range(0, 1) == 1;
        me_d_v = $urandom;
      end
      if_req = if_pend; if_addr = if_a;
      me_req = me_pend; me_addr = me_a; me_we = me_w_v; me_wdata = me_d_v;
      mem_ready = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      mem_rdata = $urandom;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
